bfp_block_exponent_sequencer: RTL and testbench

BFP_BLOCK_EXPONENT_SEQUENCER -- requirements
Module: bfp_block_exponent_sequencer

---
 rtl/bfp_block_exponent_sequencer.sv | 137 +++++++++++++
 tb/tb_bfp_block_exponent_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/bfp_block_exponent_sequencer.sv
// Block floating-point exponent sequencer: collects BLOCK_SIZE exponents, then drains per-element shifts
// relative to the block maximum. Optional macro BFP_SHIFT_SATURATE_EN clamps shifts to SHIFT_LIMIT.
module bfp_block_exponent_sequencer #(
  parameter int EXPONENT_WIDTH = 8,
  parameter int BLOCK_SIZE     = 16,
  parameter int SHIFT_LIMIT    = 15
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic signed [EXPONENT_WIDTH-1:0] in_exponent,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic        [EXPONENT_WIDTH-1:0] out_shift,
  output logic signed [EXPONENT_WIDTH-1:0] out_exponent_big,
  output logic                             out_last
);

  localparam int CNT_W = $clog2(BLOCK_SIZE);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_SIZE - 1);

  if (BLOCK_SIZE < 2 || BLOCK_SIZE > 256 || SHIFT_LIMIT < 0) begin : g_bad_params
    $error("bfp_block_exponent_sequencer: BLOCK_SIZE must be 2..256 and SHIFT_LIMIT non-negative");
  end

  typedef enum logic {
    COLLECT = 1'b0,
    DRAIN   = 1'b1
  } state_t;

  state_t                             state_q, state_d;
  logic        [CNT_W-1:0]            wr_cnt_q, wr_cnt_d;
  logic        [CNT_W-1:0]            rd_cnt_q, rd_cnt_d;
  logic signed [EXPONENT_WIDTH-1:0]   run_max_q, run_max_d;
  logic signed [EXPONENT_WIDTH-1:0]   blk_max_q, blk_max_d;
  logic signed [EXPONENT_WIDTH-1:0]   cand_max;
  logic        [EXPONENT_WIDTH-1:0]   buffer_q [BLOCK_SIZE];
  logic        [EXPONENT_WIDTH-1:0]   rd_elem;
  logic        [EXPONENT_WIDTH-1:0]   raw_shift;
  logic                               in_fire;

  assign in_fire = in_ready && in_valid;

  // First element of a block loads unconditionally; ties keep the stored value.
  always_comb begin
    cand_max = run_max_q;
    if (wr_cnt_q == '0 || in_exponent > run_max_q) begin
      cand_max = in_exponent;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= COLLECT;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      run_max_q <= '0;
      blk_max_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      run_max_q <= run_max_d;
      blk_max_q <= blk_max_d;
    end
  end

  // Element storage carries no reset so it maps onto RAM; counters guarantee no stale reads.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      buffer_q[wr_cnt_q] <= in_exponent;
    end
  end

  always_comb begin
    state_d   = state_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    run_max_d = run_max_q;
    blk_max_d = blk_max_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    case (state_q)
      COLLECT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          run_max_d = cand_max;
          if (wr_cnt_q == LAST_IDX) begin
            wr_cnt_d  = '0;
            blk_max_d = cand_max;
            state_d   = DRAIN;
          end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_last  = (rd_cnt_q == LAST_IDX);
        if (out_ready) begin
          if (rd_cnt_q == LAST_IDX) begin
            rd_cnt_d = '0;
            state_d  = COLLECT;
          end else begin
            rd_cnt_d = rd_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // The maximum is never below any element, so the modulo EXPONENT_WIDTH-bit
  // difference equals the exact (EXPONENT_WIDTH+1)-bit difference.
  assign rd_elem   = buffer_q[rd_cnt_q];
  assign raw_shift = blk_max_q - rd_elem;

  always_comb begin
    out_shift = '0;
    if (state_q == DRAIN) begin
`ifdef BFP_SHIFT_SATURATE_EN
      if (32'(raw_shift) > SHIFT_LIMIT) begin
        out_shift = EXPONENT_WIDTH'(SHIFT_LIMIT);
      end else begin
        out_shift = raw_shift;
      end
`else
      out_shift = raw_shift;
`endif
    end
  end

  assign out_exponent_big = blk_max_q;

endmodule

// File: tb/tb_bfp_block_exponent_sequencer.sv
// Directed, table-driven bench for bfp_block_exponent_sequencer (BLOCK_SIZE=4, EXPONENT_WIDTH=8).
module tb_bfp_block_exponent_sequencer;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_exponent;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_shift;
  logic [7:0] out_exponent_big;
  logic       out_last;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] last_big;

  bfp_block_exponent_sequencer #(
    .EXPONENT_WIDTH(8),
    .BLOCK_SIZE    (4),
    .SHIFT_LIMIT   (15)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_exponent     (in_exponent),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_shift       (out_shift),
    .out_exponent_big(out_exponent_big),
    .out_last        (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][7:0] din;
    logic [3:0][7:0] shift;
    logic [7:0]      big;
    bit              bubbles;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input int a0, input int a1, input int a2, input int a3,
                              input int s0, input int s1, input int s2, input int s3,
                              input int big, input bit bub);
    vec_t v;
    v.din[0] = 8'(a0); v.din[1] = 8'(a1); v.din[2] = 8'(a2); v.din[3] = 8'(a3);
    v.shift[0] = 8'(s0); v.shift[1] = 8'(s1); v.shift[2] = 8'(s2); v.shift[3] = 8'(s3);
    v.big = 8'(big);
    v.bubbles = bub;
    return v;
  endfunction

  // Starts and ends at a falling edge; ends one cycle after the final accept.
  task automatic send(input logic [3:0][7:0] din, input int n, input bit bubbles);
    for (int k = 0; k < n; k++) begin
      check("in_ready_collect", int'(in_ready), 1);
      check("big_held_collect", int'(out_exponent_big), int'(last_big));
      check("out_valid_collect", int'(out_valid), 0);
      in_valid    = 1'b1;
      in_exponent = din[k];
      @(posedge clk);
      @(negedge clk);
      if (bubbles && k < n - 1) begin
        in_valid    = 1'b0;
        in_exponent = 8'h7F;
        @(posedge clk);
        @(negedge clk);
      end
    end
    in_valid    = 1'b0;
    in_exponent = 8'h7F;
  endtask

  task automatic drain(input logic [7:0] big, input logic [3:0][7:0] shifts);
    for (int k = 0; k < 4; k++) begin
      check("out_valid_drain", int'(out_valid), 1);
      check("in_ready_drain", int'(in_ready), 0);
      check("out_exponent_big", int'(out_exponent_big), int'(big));
      check("out_shift", int'(out_shift), int'(shifts[k]));
      check("out_last", int'(out_last), (k == 3) ? 1 : 0);
      $display("out[%0d] big=%0d shift=%0d last=%0b", k, $signed(out_exponent_big), out_shift, out_last);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    out_ready = 1'b0;
    check("out_valid_after_block", int'(out_valid), 0);
    check("in_ready_after_block", int'(in_ready), 1);
    last_big = big;
  endtask

  initial begin
    vecs[0] = mk(3, 7, -2, 7,      4, 0, 9, 0,        7,   1'b0);
`ifdef BFP_SHIFT_SATURATE_EN
    vecs[1] = mk(-128, 127, 0, -1, 15, 0, 15, 15,     127, 1'b0);
`else
    vecs[1] = mk(-128, 127, 0, -1, 255, 0, 127, 128,  127, 1'b0);
`endif
    vecs[2] = mk(-5, -9, -5, -6,   0, 4, 0, 1,        -5,  1'b1);
    vecs[3] = mk(10, 20, 30, 40,   30, 20, 10, 0,     40,  1'b0);
    vecs[4] = mk(0, 0, 0, 0,       0, 0, 0, 0,        0,   1'b0);

    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_exponent = 8'h00;
    out_ready   = 1'b0;
    last_big    = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_last", int'(out_last), 0);
    check("reset_big", int'(out_exponent_big), 0);
    check("reset_shift", int'(out_shift), 0);
    check("reset_in_ready", int'(in_ready), 1);

    for (int i = 0; i < 5; i++) begin
      $display("block %0d: bubbles=%0b", i, vecs[i].bubbles);
      send(vecs[i].din, 4, vecs[i].bubbles);
      check("latency_out_valid", int'(out_valid), 1);
      drain(vecs[i].big, vecs[i].shift);
    end

    // Backpressure: stall the first output five cycles while junk is offered at the input.
    $display("block backpressure");
    send({8'd4, 8'd3, 8'd2, 8'd1}, 4, 1'b0);
    out_ready   = 1'b0;
    in_valid    = 1'b1;
    in_exponent = 8'h7F;
    for (int c = 0; c < 5; c++) begin
      check("stall_out_valid", int'(out_valid), 1);
      check("stall_shift", int'(out_shift), 3);
      check("stall_in_ready", int'(in_ready), 0);
      check("stall_big", int'(out_exponent_big), 4);
      check("stall_last", int'(out_last), 0);
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    drain(8'd4, {8'd0, 8'd1, 8'd2, 8'd3});

    // Reset during DRAIN must take effect immediately and drop the block.
    $display("block reset_in_drain");
    send({8'd9, 8'd9, 8'd9, 8'd9}, 4, 1'b0);
    check("pre_reset_out_valid", int'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    check("async_reset_out_valid", int'(out_valid), 0);
    check("async_reset_big", int'(out_exponent_big), 0);
    @(negedge clk);
    rst_n    = 1'b1;
    last_big = 8'h00;
    @(negedge clk);

    // Reset after two of four inputs; the partial block must not surface.
    $display("block reset_in_collect");
    send({8'd0, 8'd0, 8'd50, 8'd60}, 2, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_reset_in_ready", int'(in_ready), 1);
    check("mid_reset_out_valid", int'(out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send({8'd1, 8'd1, 8'd1, 8'd1}, 4, 1'b0);
    check("latency_after_reset", int'(out_valid), 1);
    drain(8'd1, {8'd0, 8'd0, 8'd0, 8'd0});
    repeat (3) begin
      check("no_extra_output", int'(out_valid), 0);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
